// File: rtl/chi_pkg.sv
// Shared CHI definitions used by the HN-F request path: request flit layout,
// request opcodes and the link-layer state encoding.
package chi_pkg;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgt_id;
    logic [6:0]  src_id;
    logic [7:0]  txn_id;
    logic [6:0]  opcode;
    logic [43:0] addr;
  } reqflit_t;

  localparam logic [6:0] REQ_LCRD_RETURN  = 7'h00;
  localparam logic [6:0] REQ_READ_SHARED  = 7'h01;
  localparam logic [6:0] REQ_READ_CLEAN   = 7'h02;
  localparam logic [6:0] REQ_READ_ONCE    = 7'h03;
  localparam logic [6:0] REQ_READ_UNIQUE  = 7'h07;
  localparam logic [6:0] REQ_WRITE_UNIQUE = 7'h18;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DEACT
  } hnf_link_state_e;

  function automatic logic is_lcrd_return(input logic [6:0] opcode);
    return opcode == REQ_LCRD_RETURN;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered storage and an occupancy count;
// pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  T                           wr_data,
  input  logic                       rd_en,
  output T                           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (rd_en) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    count_d = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: only entries below count are ever observed.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));

endmodule

// File: rtl/hnf_rxreq.sv
// HN-F RXREQ link-layer receiver: L-credit grant/return accounting, link
// activate/deactivate sequencing and a skid FIFO feeding pocq.
module hnf_rxreq
  import chi_pkg::*;
#(
  parameter int NUM_LCRD = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     link_en,
  output logic     link_idle,
  input  logic     rxreq_flitv,
  input  reqflit_t rxreq_flit,
  output logic     rxreq_lcrdv,
  output logic     req_entry_en,
  output reqflit_t req_entry,
  input  logic     pocq_full,
  output logic     proto_err
);

  localparam int CW = $clog2(NUM_LCRD + 1);
  localparam int SW = CW + 2;

  hnf_link_state_e state_q, state_d;
  logic [CW-1:0]   crd_out_q, crd_out_d;
  logic [CW-1:0]   crd_pend_q, crd_pend_d;
  logic            proto_err_q, proto_err_d;

  logic            accept, overrun, lcrd_ret, push, pop, grant;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;

  sync_fifo #(
    .T     (reqflit_t),
    .DEPTH (NUM_LCRD)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (rxreq_flit),
    .rd_en   (pop),
    .rd_data (req_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    accept   = rxreq_flitv && (crd_out_q != '0);
    overrun  = rxreq_flitv && (crd_out_q == '0);
    lcrd_ret = accept && is_lcrd_return(rxreq_flit.opcode);
    push     = accept && !lcrd_ret;
    pop      = !fifo_empty && !pocq_full;
    grant    = (state_q == ACTIVE) && (crd_pend_q != '0);

    crd_out_d   = crd_out_q + CW'(grant) - CW'(accept);
    crd_pend_d  = crd_pend_q - CW'(grant) + CW'(pop) + CW'(lcrd_ret);
    proto_err_d = proto_err_q || overrun;

    // Re-activation wins over the idle exit so a quick link_en toggle is not lost.
    state_d = state_q;
    case (state_q)
      IDLE:    if (link_en) state_d = ACTIVE;
      ACTIVE:  if (!link_en) state_d = DEACT;
      DEACT: begin
        if (link_en) begin
          state_d = ACTIVE;
        end else if ((crd_out_q == '0) && fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      crd_out_q   <= '0;
      crd_pend_q  <= CW'(NUM_LCRD);
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crd_out_q   <= crd_out_d;
      crd_pend_q  <= crd_pend_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign link_idle    = (state_q == IDLE);
  assign rxreq_lcrdv  = grant;
  assign req_entry_en = pop;
  assign proto_err    = proto_err_q;

  // Every credit is in exactly one place: at the requester, in the FIFO, or owed.
  always @(posedge clock) begin
    if (!reset) begin
      assert (SW'(crd_out_q) + SW'(fifo_count) + SW'(crd_pend_q) == SW'(NUM_LCRD));
      assert (!(push && fifo_full));
    end
  end

endmodule
